// File: rtl/hs_tx_pkg.sv
// Shared types and constants for the HS lane serializer.
//   hsState_e     : burst framing states
//   HS_SYNC_WORD  : HS sync leader, sent LSB first
//   hsParamsLegal : legality of WORD_W / OUT_W / TRAIL_CYCLES, used by elaboration checks
package hs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } hsState_e;

  localparam logic [7:0]  HS_SYNC_WORD = 8'hB8;
  localparam int unsigned SYNC_W       = 8;

  // WORD_W a non-zero multiple of 8, OUT_W a power of two up to 8, trailer at least one clock.
  function automatic bit hsParamsLegal(int unsigned wordW, int unsigned outW,
                                       int unsigned trailCycles);
    return (wordW >= 8) && ((wordW % 8) == 0) &&
           ((outW == 1) || (outW == 2) || (outW == 4) || (outW == 8)) &&
           (trailCycles >= 1);
  endfunction

endpackage

// File: rtl/hs_tx_shifter.sv
// Shift register and beat counter for one unit (sync byte or data word).
// The register holds only the bits of the unit not yet placed on the line;
// the first beat of a unit goes out directly from the load value.
//   clk, rstN  : clock, synchronous active-low reset
//   load       : capture loadWord (minus its first beat), counter to 0
//   loadSync   : the unit being loaded is the 8-bit sync leader
//   loadWord   : unit to load, bit 0 earliest
//   shift      : advance one beat
//   clear      : return counter to 0 at burst end
//   nextBits   : beat to place on the line at the next shift
//   lastBeat   : the last beat of the current unit is on the line
module hs_tx_shifter
  import hs_tx_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OUT_W  = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              load,
  input  logic              loadSync,
  input  logic [WORD_W-1:0] loadWord,
  input  logic              shift,
  input  logic              clear,
  output logic [OUT_W-1:0]  nextBits,
  output logic              lastBeat
);

  localparam int unsigned DATA_BEATS = WORD_W / OUT_W;
  localparam int unsigned SYNC_BEATS = SYNC_W / OUT_W;
  localparam int unsigned CNT_W      = $clog2(DATA_BEATS + 1);

  logic [WORD_W-1:0] shReg;
  logic [CNT_W-1:0]  beatCnt;
  logic              unitSync;

  // Unit storage and beat position
  always_ff @(posedge clk) begin
    if (!rstN) begin
      shReg    <= '0;
      beatCnt  <= '0;
      unitSync <= 1'b0;
    end else if (load) begin
      shReg    <= loadWord >> OUT_W;
      beatCnt  <= '0;
      unitSync <= loadSync;
    end else if (shift) begin
      shReg    <= shReg >> OUT_W;
      beatCnt  <= beatCnt + CNT_W'(1);
    end else if (clear) begin
      beatCnt  <= '0;
    end
  end

  assign nextBits = shReg[OUT_W-1:0];
  assign lastBeat = (beatCnt == (unitSync ? CNT_W'(SYNC_BEATS - 1) : CNT_W'(DATA_BEATS - 1)));

endmodule

// File: rtl/hs_lane_serializer.sv
// HS serializer for one D-PHY data lane, running on the serial-rate clock.
// Frames a burst: sync leader, gap-free data words via valid/ready, then trailer.
//   TxDDRClkHS    : serial-rate clock
//   TxRst_n       : synchronous active-low reset
//   TxRequestHS   : burst request, high for the whole burst
//   TxWordHS_Data : payload word, bit 0 first
//   TxWordValidHS : payload word valid
//   TxReadyHS     : word accepted when high together with TxWordValidHS (combinational)
//   Serial_Bits   : OUT_W-bit line beat, bit 0 earliest
//   Serial_Active : HS driver enable
//   Underflow     : sticky, burst ended because data was starved
module hs_lane_serializer
  import hs_tx_pkg::*;
#(
  parameter int unsigned WORD_W       = 8,
  parameter int unsigned OUT_W        = 2,
  parameter int unsigned TRAIL_CYCLES = 4
) (
  input  logic              TxDDRClkHS,
  input  logic              TxRst_n,
  input  logic              TxRequestHS,
  input  logic [WORD_W-1:0] TxWordHS_Data,
  input  logic              TxWordValidHS,
  output logic              TxReadyHS,
  output logic [OUT_W-1:0]  Serial_Bits,
  output logic              Serial_Active,
  output logic              Underflow
);

  if (!hsParamsLegal(WORD_W, OUT_W, TRAIL_CYCLES)) begin : gBadParams
    $error("hs_lane_serializer: illegal WORD_W / OUT_W / TRAIL_CYCLES combination");
  end

  localparam int unsigned TRAIL_W = $clog2(TRAIL_CYCLES + 1);

  hsState_e           state, stateNext;
  logic [TRAIL_W-1:0] trailCnt, trailCntNext;
  logic [OUT_W-1:0]   serialBitsNext;
  logic               activeNext, underflowNext;

  logic               shLoad, shLoadSync, shShift, shClear;
  logic [WORD_W-1:0]  shLoadWord;
  logic [OUT_W-1:0]   shNextBits;
  logic               shLastBeat;

  logic               unitEnd, accept, trailDone;

  hs_tx_shifter #(
    .WORD_W (WORD_W),
    .OUT_W  (OUT_W)
  ) uShifter (
    .clk      (TxDDRClkHS),
    .rstN     (TxRst_n),
    .load     (shLoad),
    .loadSync (shLoadSync),
    .loadWord (shLoadWord),
    .shift    (shShift),
    .clear    (shClear),
    .nextBits (shNextBits),
    .lastBeat (shLastBeat)
  );

  // Ready only while the final beat of a unit is on the line, so the next word follows without a bubble
  assign unitEnd   = ((state == SYNC) || (state == DATA)) && shLastBeat;
  assign TxReadyHS = unitEnd && TxRequestHS;
  assign accept    = TxReadyHS && TxWordValidHS;
  assign trailDone = (trailCnt == TRAIL_W'(TRAIL_CYCLES - 1));

  // State register
  always_ff @(posedge TxDDRClkHS) begin
    if (!TxRst_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:       if (TxRequestHS) stateNext = SYNC;
      SYNC, DATA: if (unitEnd)     stateNext = accept ? DATA : TRAIL;
      TRAIL:      if (trailDone)   stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // Next values for the output registers and shifter controls
  always_comb begin
    serialBitsNext = Serial_Bits;
    activeNext     = Serial_Active;
    underflowNext  = Underflow;
    trailCntNext   = trailCnt;
    shLoad         = 1'b0;
    shLoadSync     = 1'b0;
    shShift        = 1'b0;
    shClear        = 1'b0;
    shLoadWord     = TxWordHS_Data;
    case (state)
      IDLE: begin
        if (TxRequestHS) begin
          shLoad         = 1'b1;
          shLoadSync     = 1'b1;
          shLoadWord     = WORD_W'(HS_SYNC_WORD);
          serialBitsNext = HS_SYNC_WORD[OUT_W-1:0];
          activeNext     = 1'b1;
          underflowNext  = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (!unitEnd) begin
          shShift        = 1'b1;
          serialBitsNext = shNextBits;
        end else if (accept) begin
          shLoad         = 1'b1;
          serialBitsNext = TxWordHS_Data[OUT_W-1:0];
        end else begin
          // Still requesting but nothing offered: starved
          if (TxRequestHS) underflowNext = 1'b1;
          // Trailer is the inverse of the last bit sent
          serialBitsNext = {OUT_W{~Serial_Bits[OUT_W-1]}};
          trailCntNext   = '0;
          shClear        = 1'b1;
        end
      end
      TRAIL: begin
        if (trailDone) begin
          serialBitsNext = '0;
          activeNext     = 1'b0;
        end else begin
          trailCntNext   = trailCnt + TRAIL_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge TxDDRClkHS) begin
    if (!TxRst_n) begin
      Serial_Bits   <= '0;
      Serial_Active <= 1'b0;
      Underflow     <= 1'b0;
      trailCnt      <= '0;
    end else begin
      Serial_Bits   <= serialBitsNext;
      Serial_Active <= activeNext;
      Underflow     <= underflowNext;
      trailCnt      <= trailCntNext;
    end
  end

endmodule

// File: tb/tb_hs_lane_serializer.sv
// Bench for hs_lane_serializer: lane A (8-bit words, 2 bits/clk) and lane B (16-bit words, 1 bit/clk),
// both checked every cycle against a bit-queue model of the line.
module tb_hs_lane_serializer;

  localparam int unsigned WA = 8;
  localparam int unsigned OA = 2;
  localparam int unsigned WB = 16;
  localparam int unsigned OB = 1;
  localparam int unsigned TC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic          reqA, validA, readyA, actA, ufA;
  logic [WA-1:0] dataA;
  logic [OA-1:0] bitsA;
  logic          reqB, validB, readyB, actB, ufB;
  logic [WB-1:0] dataB;
  logic [OB-1:0] bitsB;

  hs_lane_serializer #(.WORD_W(WA), .OUT_W(OA), .TRAIL_CYCLES(TC)) dutA (
    .TxDDRClkHS(clk), .TxRst_n(rstN), .TxRequestHS(reqA), .TxWordHS_Data(dataA),
    .TxWordValidHS(validA), .TxReadyHS(readyA), .Serial_Bits(bitsA),
    .Serial_Active(actA), .Underflow(ufA)
  );

  hs_lane_serializer #(.WORD_W(WB), .OUT_W(OB), .TRAIL_CYCLES(TC)) dutB (
    .TxDDRClkHS(clk), .TxRst_n(rstN), .TxRequestHS(reqB), .TxWordHS_Data(dataB),
    .TxWordValidHS(validB), .TxReadyHS(readyB), .Serial_Bits(bitsB),
    .Serial_Active(actB), .Underflow(ufB)
  );

  int nCmp = 0;
  int nErr = 0;

  // Model: phase 0 idle, 1 sending units, 2 trailer; q holds line bits not yet sent
  int         mPhase[2];
  int         mTrail[2];
  logic [7:0] mBits[2];
  logic       mAct[2];
  logic       mUf[2];
  bit         q0[$];
  bit         q1[$];

  bit         accFlag[2];
  int         readyCnt[2];
  logic [7:0] log0[$];
  logic [7:0] log1[$];

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int qSize(int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qPush(int l, bit b);
    if (l == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic bit qPop(int l);
    if (l == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic logic [7:0] popBeat(int l, int ow);
    logic [7:0] v = '0;
    for (int i = 0; i < ow; i++) v[i] = qPop(l);
    return v;
  endfunction

  function automatic void pushWord(int l, logic [15:0] w, int nb);
    for (int i = 0; i < nb; i++) qPush(l, w[i]);
  endfunction

  function automatic bit predReady(int l, logic req);
    return (mPhase[l] == 1) && (qSize(l) == 0) && (req == 1'b1);
  endfunction

  // Advance the model across one rising edge with the given sampled inputs
  function automatic void modelStep(int l, int ow, int ww, logic rst, logic req,
                                    logic valid, logic [15:0] w);
    if (!rst) begin
      mPhase[l] = 0;
      mBits[l]  = '0;
      mAct[l]   = 1'b0;
      mUf[l]    = 1'b0;
      if (l == 0) q0.delete();
      else        q1.delete();
      return;
    end
    case (mPhase[l])
      0: if (req) begin
        pushWord(l, 16'h00B8, 8);
        mBits[l]  = popBeat(l, ow);
        mAct[l]   = 1'b1;
        mUf[l]    = 1'b0;
        mPhase[l] = 1;
      end
      1: begin
        if (qSize(l) > 0) mBits[l] = popBeat(l, ow);
        else if (req && valid) begin
          pushWord(l, w, ww);
          mBits[l] = popBeat(l, ow);
        end else begin
          if (req) mUf[l] = 1'b1;
          mBits[l]  = mBits[l][ow-1] ? 8'h00 : 8'((1 << ow) - 1);
          mPhase[l] = 2;
          mTrail[l] = TC - 1;
        end
      end
      2: begin
        if (mTrail[l] == 0) begin
          mPhase[l] = 0;
          mBits[l]  = '0;
          mAct[l]   = 1'b0;
        end else mTrail[l]--;
      end
      default: ;
    endcase
  endfunction

  // One clock: compare at the falling edge, step the model, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    chk("A.bits",      16'(bitsA),  16'(mBits[0][OA-1:0]));
    chk("A.active",    16'(actA),   16'(mAct[0]));
    chk("A.underflow", 16'(ufA),    16'(mUf[0]));
    chk("A.ready",     16'(readyA), 16'(predReady(0, reqA)));
    chk("B.bits",      16'(bitsB),  16'(mBits[1][OB-1:0]));
    chk("B.active",    16'(actB),   16'(mAct[1]));
    chk("B.underflow", 16'(ufB),    16'(mUf[1]));
    chk("B.ready",     16'(readyB), 16'(predReady(1, reqB)));
    accFlag[0] = readyA && validA;
    accFlag[1] = readyB && validB;
    if (readyA) readyCnt[0]++;
    if (readyB) readyCnt[1]++;
    if (actA) log0.push_back(8'(bitsA));
    if (actB) log1.push_back(8'(bitsB));
    modelStep(0, OA, WA, rstN, reqA, validA, 16'(dataA));
    modelStep(1, OB, WB, rstN, reqB, validB, dataB);
    @(posedge clk);
    #2;
  endtask

  task automatic setIn(int l, logic req, logic valid, logic [15:0] d);
    if (l == 0) begin
      reqA = req; validA = valid; dataA = d[7:0];
    end else begin
      reqB = req; validB = valid; dataB = d;
    end
  endtask

  task automatic clrLog(int l);
    if (l == 0) log0.delete();
    else        log1.delete();
    readyCnt[l] = 0;
  endtask

  task automatic chkLog(string nm, int l, input logic [7:0] exp[$]);
    logic [7:0] got[$];
    if (l == 0) got = log0;
    else        got = log1;
    chk({nm, ".len"}, 16'(got.size()), 16'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      logic [7:0] g;
      g = (i < got.size()) ? got[i] : 8'hEE;
      chk($sformatf("%s.beat%0d", nm, i), 16'(g), 16'(exp[i]));
    end
  endtask

  // Drive one burst; valid offered with validPct probability, held until accepted
  task automatic runBurst(int l, input logic [15:0] words[$], int validPct, bit keepReq);
    int   idx = 0;
    int   g1 = 0, g2 = 0;
    logic v = 1'b0;
    do begin
      if (!v && idx < words.size()) v = ($urandom_range(99) < validPct);
      setIn(l, 1'b1, v, (idx < words.size()) ? words[idx] : 16'h0);
      cyc();
      g1++;
      if (accFlag[l]) begin
        idx++;
        v = 1'b0;
      end
    end while (idx < words.size() && mPhase[l] != 2 && g1 < 400);
    setIn(l, keepReq, 1'b0, 16'h0);
    while (mPhase[l] != 2 && g2 < 400) begin cyc(); g2++; end
    setIn(l, 1'b0, 1'b0, 16'h0);
    while (mPhase[l] != 0 && g2 < 400) begin cyc(); g2++; end
    chk("burst.timeout", 16'((g1 >= 400) || (g2 >= 400)), 16'h0);
    cyc();
  endtask

  initial begin
    logic [7:0]  e[$];
    logic [15:0] w[$];
    int          g;

    for (int l = 0; l < 2; l++) begin
      mPhase[l] = 0; mTrail[l] = 0; mBits[l] = '0; mAct[l] = 1'b0; mUf[l] = 1'b0;
      accFlag[l] = 1'b0; readyCnt[l] = 0;
    end

    // Reset held 3 clocks with request and valid high
    rstN = 1'b0;
    setIn(0, 1'b1, 1'b1, 16'h33);
    setIn(1, 1'b1, 1'b1, 16'h8001);
    @(posedge clk);
    #2;
    repeat (2) cyc();
    chk("reset.bitsA",   16'(bitsA),  16'h0);
    chk("reset.activeA", 16'(actA),   16'h0);
    chk("reset.readyA",  16'(readyA), 16'h0);
    chk("reset.ufA",     16'(ufA),    16'h0);
    chk("reset.activeB", 16'(actB),   16'h0);
    chk("reset.noSync",  16'(log0.size() + log1.size()), 16'h0);
    rstN = 1'b1;
    setIn(0, 1'b0, 1'b0, 16'h0);
    setIn(1, 1'b0, 1'b0, 16'h0);
    cyc();

    // Single word
    clrLog(0);
    w = '{16'h0033};
    runBurst(0, w, 100, 1'b0);
    e = '{8'd0, 8'd2, 8'd3, 8'd2, 8'd3, 8'd0, 8'd3, 8'd0, 8'd3, 8'd3, 8'd3, 8'd3};
    chkLog("single", 0, e);
    chk("single.readyCycles", 16'(readyCnt[0]), 16'd1);

    // Back-to-back words
    clrLog(0);
    w = '{16'h0033, 16'h00C3};
    runBurst(0, w, 100, 1'b0);
    e = '{8'd0, 8'd2, 8'd3, 8'd2, 8'd3, 8'd0, 8'd3, 8'd0,
          8'd3, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    chkLog("b2b", 0, e);
    chk("b2b.readyCycles", 16'(readyCnt[0]), 16'd2);

    // Underflow: request held, never valid
    clrLog(0);
    w.delete();
    runBurst(0, w, 0, 1'b1);
    e = '{8'd0, 8'd2, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
    chkLog("underflow", 0, e);
    chk("underflow.sticky", 16'(ufA), 16'h1);

    // Request dropped mid-word; also underflow clears at burst start
    clrLog(0);
    setIn(0, 1'b1, 1'b1, 16'h005A);
    cyc();
    chk("underflow.cleared", 16'(ufA), 16'h0);
    g = 0;
    while (!accFlag[0] && g < 20) begin cyc(); g++; end
    chk("drop.acceptSeen", 16'(accFlag[0]), 16'h1);
    setIn(0, 1'b1, 1'b1, 16'h00FF);
    cyc();
    setIn(0, 1'b0, 1'b1, 16'h00FF);
    g = 0;
    while (mPhase[0] != 0 && g < 50) begin cyc(); g++; end
    setIn(0, 1'b0, 1'b0, 16'h0);
    cyc();
    e = '{8'd0, 8'd2, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3};
    chkLog("drop", 0, e);
    chk("drop.noUnderflow", 16'(ufA), 16'h0);

    // Reset during the second data beat
    clrLog(0);
    setIn(0, 1'b1, 1'b1, 16'h0033);
    repeat (6) cyc();
    rstN = 1'b0;
    cyc();
    chk("midReset.bits",   16'(bitsA),  16'h0);
    chk("midReset.active", 16'(actA),   16'h0);
    chk("midReset.ready",  16'(readyA), 16'h0);
    chk("midReset.beats",  16'(log0.size()), 16'd6);
    rstN = 1'b1;
    setIn(0, 1'b0, 1'b0, 16'h0);
    repeat (2) cyc();

    // Randomized bursts on lane A
    repeat (25) begin
      w.delete();
      repeat ($urandom_range(1, 4)) w.push_back(16'($urandom_range(255)));
      runBurst(0, w, $urandom_range(40, 100), 1'($urandom_range(1)));
    end

    // Wide word, 1 bit per clock
    clrLog(1);
    w = '{16'h8001};
    runBurst(1, w, 100, 1'b0);
    e = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1};
    repeat (14) e.push_back(8'd0);
    e.push_back(8'd1);
    repeat (4) e.push_back(8'd0);
    chkLog("sweep", 1, e);

    // Randomized bursts on lane B
    repeat (6) begin
      w.delete();
      repeat ($urandom_range(1, 3)) w.push_back(16'($urandom_range(65535)));
      runBurst(1, w, $urandom_range(60, 100), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
